// File: rtl/satatrn_pkg.sv
// rtl/satatrn_pkg.sv - shared SATA transport-layer constants and types
//
// FIS_DATA          : FIS type code of a DATA FIS, used as the inserted header word
// SATA_MAXFIS_WORDS : largest FIS in 32-bit words (header + 2048 payload dwords)
// txmux_state_t     : transmit mux packet state
package satatrn_pkg;

    localparam logic [7:0] FIS_DATA          = 8'h46;
    localparam int         SATA_MAXFIS_WORDS = 2049;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_PKT   = 2'd1,
        TX_DRAIN = 2'd2
    } txmux_state_t;

endpackage

// File: rtl/satatrn_txmux_arb.sv
// rtl/satatrn_txmux_arb.sv - combinational winner select: first eligible at/after ptr
//
// Ports:
//   eligible  in   NCH        per-channel request
//   ptr       in   CW         search start; tie to 0 for fixed lowest-index priority
//   any       out  1          at least one channel eligible
//   win       out  CW         winning channel index (0 when none)
//   onehot    out  NCH        winning channel one-hot (all zero when none)
module satatrn_txmux_arb #(
    parameter int NCH = 3
) (
    input  logic [NCH-1:0]         eligible,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic                   any,
    output logic [$clog2(NCH)-1:0] win,
    output logic [NCH-1:0]         onehot
);

    localparam int CW = $clog2(NCH);

    // Walk the ring from the far end back toward ptr so the entry closest to
    // ptr is the last one written and therefore the winner.
    always_comb begin : pick
        int idx;
        any    = 1'b0;
        win    = '0;
        onehot = '0;
        idx    = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (eligible[idx]) begin
                any = 1'b1;
                win = CW'(idx);
            end
        end
        onehot[win] = any;
    end

endmodule

// File: rtl/satatrn_txmux.sv
// rtl/satatrn_txmux.sv - packet-atomic N-channel transmit arbiter onto the link-layer stream
//
// Optional feature macro: SATATRN_TXMUX_ROUNDROBIN_EN (round-robin between packets;
// fixed lowest-index priority when undefined).
//
// Ports:
//   i_clk     in   1             PHY clock
//   i_reset   in   1             asynchronous active-high reset
//   i_valid   in   NCH           per-channel word valid
//   o_ready   out  NCH           per-channel word accept (combinational)
//   i_data    in   NCH*DW        channel c word in bits [c*DW +: DW]
//   i_last    in   NCH           per-channel end of packet
//   i_txgate  in   NCH           start permission for header-inserting channels
//   o_valid   out  1             output word valid
//   i_ready   in   1             link-layer accept
//   o_data    out  DW            output word
//   o_last    out  1             output end of packet
//   o_chan    out  clog2(NCH)    channel owning o_data
//   o_trunc   out  1             pulse: packet cut at MAXBEATS
module satatrn_txmux
    import satatrn_pkg::*;
#(
    parameter int              NCH          = 3,
    parameter int              DW           = 32,
    parameter logic [NCH-1:0]  HDR_MASK     = 3'b010,
    parameter logic [DW-1:0]   HDR_WORD     = DW'(FIS_DATA),
    parameter int              MAXBEATS     = SATA_MAXFIS_WORDS,
    parameter bit              OPT_LOWPOWER = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NCH-1:0]         i_valid,
    output logic [NCH-1:0]         o_ready,
    input  logic [NCH*DW-1:0]      i_data,
    input  logic [NCH-1:0]         i_last,
    input  logic [NCH-1:0]         i_txgate,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [DW-1:0]          o_data,
    output logic                   o_last,
    output logic [$clog2(NCH)-1:0] o_chan,
    output logic                   o_trunc
);

    localparam int                CW       = $clog2(NCH);
    localparam int                LGMAX    = $clog2(MAXBEATS + 1);
    localparam logic [LGMAX-1:0]  TRUNC_AT = LGMAX'(MAXBEATS - 1);

    logic [DW-1:0]    ch_data [NCH];
    txmux_state_t     state, state_nxt;
    logic [CW-1:0]    grant, grant_nxt;
    logic [LGMAX-1:0] count, count_nxt;
    logic             valid_nxt, last_nxt, trunc_nxt;
    logic [DW-1:0]    data_nxt;
    logic [CW-1:0]    chan_nxt;
    logic [NCH-1:0]   eligible, ready_c, arb_onehot;
    logic             arb_any;
    logic [CW-1:0]    arb_win, rr_ptr;
    logic             advance;

    for (genvar g = 0; g < NCH; g++) begin : g_slice
        assign ch_data[g] = i_data[g*DW +: DW];
    end

    // Single output register: it may load whenever it is empty or being drained.
    assign advance  = !o_valid || i_ready;

    // Header channels may only start once the transport layer opens their gate.
    assign eligible = i_valid & (~HDR_MASK | i_txgate);

    satatrn_txmux_arb #(
        .NCH (NCH)
    ) u_arb (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .any      (arb_any),
        .win      (arb_win),
        .onehot   (arb_onehot)
    );

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        count_nxt = count;
        valid_nxt = o_valid;
        data_nxt  = o_data;
        last_nxt  = o_last;
        chan_nxt  = o_chan;
        trunc_nxt = 1'b0;
        ready_c   = '0;

        case (state)
            TX_IDLE: begin
                if (advance) begin
                    if (arb_any) begin
                        grant_nxt = arb_win;
                        chan_nxt  = arb_win;
                        count_nxt = LGMAX'(1);
                        valid_nxt = 1'b1;
                        if (HDR_MASK[arb_win]) begin
                            // Header occupies the first beat; the channel's
                            // first word waits for the PKT state.
                            data_nxt  = HDR_WORD;
                            last_nxt  = 1'b0;
                            state_nxt = TX_PKT;
                        end else begin
                            ready_c   = arb_onehot;
                            data_nxt  = ch_data[arb_win];
                            last_nxt  = i_last[arb_win];
                            state_nxt = i_last[arb_win] ? TX_IDLE : TX_PKT;
                        end
                    end else begin
                        valid_nxt = 1'b0;
                    end
                end
            end

            TX_PKT: begin
                if (advance) begin
                    ready_c[grant] = 1'b1;
                    valid_nxt      = i_valid[grant];
                    if (i_valid[grant]) begin
                        data_nxt  = ch_data[grant];
                        last_nxt  = i_last[grant];
                        count_nxt = count + LGMAX'(1);
                        if (i_last[grant]) begin
                            state_nxt = TX_IDLE;
                        end else if (count == TRUNC_AT) begin
                            // Oversized packet: close it off on the link and
                            // swallow the remainder of the source packet.
                            last_nxt  = 1'b1;
                            trunc_nxt = 1'b1;
                            state_nxt = TX_DRAIN;
                        end
                    end
                end
            end

            TX_DRAIN: begin
                ready_c[grant] = 1'b1;
                if (advance) begin
                    valid_nxt = 1'b0;
                end
                if (i_valid[grant] && i_last[grant]) begin
                    state_nxt = TX_IDLE;
                end
            end

            default: begin
                state_nxt = TX_IDLE;
            end
        endcase

        if (OPT_LOWPOWER && !valid_nxt) begin
            data_nxt = '0;
            last_nxt = 1'b0;
        end
    end

    // Nothing is accepted while reset is held, so no word is lost from a source.
    assign o_ready = i_reset ? '0 : ready_c;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= TX_IDLE;
            grant   <= '0;
            count   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_chan  <= '0;
            o_trunc <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            count   <= count_nxt;
            o_valid <= valid_nxt;
            o_data  <= data_nxt;
            o_last  <= last_nxt;
            o_chan  <= chan_nxt;
            o_trunc <= trunc_nxt;
        end
    end

`ifdef SATATRN_TXMUX_ROUNDROBIN_EN
    // A packet ends exactly when a source word carrying i_last is accepted;
    // the owner then drops to the back of the ring.
    logic [NCH-1:0] ended;
    logic [CW-1:0]  ended_chan;

    assign ended = ready_c & i_valid & i_last;

    always_comb begin
        ended_chan = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ended[c]) begin
                ended_chan = CW'(c);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rr_ptr <= '0;
        end else if (|ended) begin
            rr_ptr <= (ended_chan == CW'(NCH - 1)) ? '0 : ended_chan + CW'(1);
        end
    end
`else
    assign rr_ptr = '0;
`endif

endmodule
